// File: rtl/pc_gen.sv
// Fetch program-counter generator with buffered redirects and exception entry.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects trap to EXC_VEC and pulse misalign.
module pc_gen #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      INSTR_BYTES = 4,
   parameter logic [WIDTH-1:0] RESET_VEC   = '0,
   parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(32'h0000_0080)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hit,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc_valid,
   output logic [WIDTH-1:0] pc_out,
   output logic             pc_valid,
   output logic             flush,
`ifdef PC_MISALIGN_TRAP_EN
   output logic             misalign,
`endif
   output logic             pend
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_e;

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
   localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             valid_q, valid_d;
   logic             flush_q, flush_d;
   logic             mis_q, mis_d;

   logic             adv;
   logic             trap;
   logic [WIDTH-1:0] aligned_tgt;

   assign adv         = hit & ~stall;
   assign aligned_tgt = redir_target & ~LOW_MASK;

`ifdef PC_MISALIGN_TRAP_EN
   assign trap = redir_valid & (|(redir_target & LOW_MASK));
`else
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_VEC;
         tgt_q   <= '0;
         valid_q <= 1'b1;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   // Priority: exception (or misalign trap) > redirect > pending apply > advance > hold.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      valid_d = valid_q;
      flush_d = 1'b0;
      mis_d   = 1'b0;
      if (exc_valid || trap) begin
         state_d = RUN;
         pc_d    = EXC_VEC;
         valid_d = 1'b1;
         flush_d = 1'b1;
         mis_d   = ~exc_valid;
      end else if (redir_valid) begin
         if (adv) begin
            state_d = RUN;
            pc_d    = aligned_tgt;
            valid_d = 1'b1;
            flush_d = 1'b1;
         end else begin
            state_d = PEND;
            tgt_d   = aligned_tgt;
            valid_d = 1'b0;
         end
      end else if (state_q == PEND) begin
         if (adv) begin
            state_d = RUN;
            pc_d    = tgt_q;
            valid_d = 1'b1;
            flush_d = 1'b1;
         end
      end else if (adv) begin
         pc_d = pc_q + STEP;
      end
   end

   always_comb begin
      pc_out   = pc_q;
      pc_valid = valid_q;
      flush    = flush_q;
      pend     = (state_q == PEND);
`ifdef PC_MISALIGN_TRAP_EN
      misalign = mis_q;
`endif
   end

`ifndef PC_MISALIGN_TRAP_EN
   logic unused_mis;
   assign unused_mis = mis_q;
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the instruction-fetch stage; successor to the fixed 32-bit PC register.
- Holds the fetch PC and advances it by INSTR_BYTES whenever fetch may proceed, i.e. on an I-cache hit with no pipeline stall.
- Accepts branch/jump redirects and exception entry.
- If a redirect arrives while fetch is stalled, it is buffered and applied when the stall clears.
- Feeds the I-cache address and the IF/ID pipeline register.

Parameters:
WIDTH, 32, PC width in bits
INSTR_BYTES, 4, increment per fetch; power of two, at least 1
RESET_VEC, 0, PC value loaded on reset
EXC_VEC, 32'h0000_0080, exception entry PC (truncated to WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
hit  in  1  I-cache hit for the current pc_out; 0 = fetch stall
stall  in  1  hazard stall from decode; 1 = hold PC
redir_valid  in  1  branch/jump redirect request, single-cycle
redir_target  in  WIDTH  redirect destination
exc_valid  in  1  exception entry request, single-cycle
pc_out  out  WIDTH  current fetch PC
pc_valid  out  1  pc_out is on the correct path
flush  out  1  one-cycle pulse when pc_out was just loaded from a redirect or exception
pend  out  1  a buffered redirect is waiting

Behaviour:
- Reset: every clock edge with rst=1 sets pc_out=RESET_VEC, pc_valid=1, flush=0, pend=0, and clears the pending register. Reset mid-operation discards any pending redirect.
- Define adv = hit & ~stall.
- State machine:
  - RUN: no pending redirect.
  - PEND: pending target held.
  - pend=1 exactly in PEND.
- Per-edge priority (rst excluded): exc_valid > redir_valid > pending-apply > advance > hold.
- exc_valid=1, in any state and regardless of adv:
  - pc_out<=EXC_VEC, flush<=1, pc_valid<=1.
  - Pending is cleared; next state is RUN.
- redir_valid=1 and adv=1:
  - pc_out<=aligned target, flush<=1.
  - Next state is RUN; any older pending target is dropped.
- redir_valid=1 and adv=0:
  - Pending register <= aligned target; next state is PEND.
  - pc_out is held; pc_valid<=0.
  - A newer redirect overwrites an older pending target (newest wins).
- PEND with adv=1 and no new redirect/exception: pc_out<=pending target, flush<=1, pc_valid<=1, next state RUN.
- PEND with adv=0: hold everything; pc_valid stays 0.
- RUN with adv=1: pc_out<=pc_out+INSTR_BYTES, computed modulo 2^WIDTH (the 0xFFFF_FFFC -> 0 wrap is silent). flush<=0.
- RUN with adv=0: pc_out held, flush<=0.
- Alignment: the aligned target is redir_target with its low log2(INSTR_BYTES) bits cleared. See the optional feature for the alternative.
- Latency: one cycle from a request to the updated pc_out. flush is registered and coincides with the first cycle the new pc_out is visible.
- Simultaneous redir_valid and exc_valid: the exception wins and the redirect is discarded.

Optional Feature:
PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose low log2(INSTR_BYTES) bits are nonzero is not taken and is not buffered.
  - It is treated exactly as exc_valid: pc_out<=EXC_VEC and flush<=1.
  - Extra output misalign (1 bit) pulses for one cycle, aligned with flush.
- Undefined:
  - Low bits are silently cleared.
  - The misalign port does not exist.

Test Plan:
- rst=1 for 2 cycles, then hit=1, stall=0 for 4 cycles -> pc_out 0,4,8,12,16; pc_valid=1; flush=0.
- pc_out=0x40, hit=0 for 3 cycles -> pc_out stays 0x40; hit=1 -> next pc_out=0x44.
- pc_out=0x10, adv=1, redir_valid with target 0x200 -> next cycle pc_out=0x200, flush=1 for 1 cycle, then 0x204.
- stall=1, redir to 0x300, then redir to 0x400 a cycle later:
  - pend=1 and pc_valid=0 while stalled.
  - On stall=0 -> pc_out=0x400, flush=1, pend=0.
- In PEND with exc_valid=1 -> pc_out=0x80, pend=0, flush=1. Separately, rst asserted in PEND -> pc_out=0, pend=0.
- pc_out=0xFFFF_FFFC with adv=1 -> pc_out=0. Redirect to 0x103:
  - PC_MISALIGN_TRAP_EN undefined -> pc_out=0x100.
  - PC_MISALIGN_TRAP_EN defined -> pc_out=0x80, misalign=1.
